// File: rtl/iteration_scheduler_if.sv
// Control bundle between the global iteration scheduler and the cores/host.
// The master side drives run requests and per-core status. The slave side
// (the scheduler) drives iteration control back.
interface iteration_scheduler_if #(
  parameter int CORE_NUM   = 4,
  parameter int ITER_WIDTH = 16
);
  logic                  start;
  logic [ITER_WIDTH-1:0] max_iteration;
  logic [CORE_NUM-1:0]   front_iteration_end;
  logic [CORE_NUM-1:0]   front_iteration_end_valid;
  logic [CORE_NUM-1:0]   front_active_v_updated;
  logic [CORE_NUM-1:0]   front_active_v_valid;
  logic                  iteration_start;
  logic [ITER_WIDTH-1:0] iteration_id;
  logic [CORE_NUM-1:0]   core_rst;
  logic                  busy;
  logic                  done;
  logic                  done_converged;

  modport master (
    output start, max_iteration,
    output front_iteration_end, front_iteration_end_valid,
    output front_active_v_updated, front_active_v_valid,
    input  iteration_start, iteration_id, core_rst,
    input  busy, done, done_converged
  );

  modport slave (
    input  start, max_iteration,
    input  front_iteration_end, front_iteration_end_valid,
    input  front_active_v_updated, front_active_v_valid,
    output iteration_start, iteration_id, core_rst,
    output busy, done, done_converged
  );
endinterface

// File: rtl/iteration_scheduler.sv
// Global iteration sequencer. It waits until every core reports iteration end
// for a stable run of cycles, flushes the cores for one cycle, and then either
// starts the next iteration or stops. It stops on convergence, on the
// iteration limit, or when the iteration counter is exhausted.
module iteration_scheduler #(
  parameter int CORE_NUM      = 4,
  parameter int ITER_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  iteration_scheduler_if.slave  bus
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]         SETTLE_ONE  = SW'(1);
  localparam logic [ITER_WIDTH-1:0] ITER_ONE    = ITER_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWITCH, S_DONE} state_t;

  state_t                state_q;
  logic [SW-1:0]         settle_q;
  logic                  seen_q;
  logic [ITER_WIDTH-1:0] limit_q;
  logic [ITER_WIDTH-1:0] id_q;
  logic                  iter_start_q;
  logic [CORE_NUM-1:0]   core_rst_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  conv_q;

  logic all_end;
  logic any_update;

  // A core counts as ended only when its end flag is qualified by end_valid.
  assign all_end    = &(bus.front_iteration_end & bus.front_iteration_end_valid);
  assign any_update = |(bus.front_active_v_updated & bus.front_active_v_valid);

  assign bus.iteration_start = iter_start_q;
  assign bus.iteration_id    = id_q;
  assign bus.core_rst        = core_rst_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.done_converged  = conv_q;

  // Sequencer FSM. Every output is registered here together with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      seen_q       <= 1'b0;
      limit_q      <= '0;
      id_q         <= '0;
      iter_start_q <= 1'b0;
      core_rst_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      conv_q       <= 1'b0;
    end else begin
      iter_start_q <= 1'b0;
      core_rst_q   <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q      <= S_RUN;
            id_q         <= '0;
            iter_start_q <= 1'b1;
            limit_q      <= bus.max_iteration;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            conv_q       <= 1'b0;
            seen_q       <= 1'b0;
            settle_q     <= '0;
          end
        end
        S_RUN: begin
          if (any_update) seen_q <= 1'b1;
          // End flags are still stale in the first cycle of an iteration.
          if (!iter_start_q) begin
            if (all_end) begin
              if (settle_q == SETTLE_LAST) begin
                state_q    <= S_SWITCH;
                core_rst_q <= '1;
                settle_q   <= '0;
              end else begin
                settle_q <= settle_q + SETTLE_ONE;
              end
            end else begin
              settle_q <= '0;
            end
          end
        end
        S_SWITCH: begin
          if (!seen_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            conv_q  <= 1'b1;
          end else if ((limit_q != '0) && (id_q == limit_q - ITER_ONE)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            conv_q  <= 1'b0;
          end else if (&id_q) begin
            // The counter does not wrap; running out of ids ends the run.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            conv_q  <= 1'b0;
          end else begin
            state_q      <= S_RUN;
            id_q         <= id_q + ITER_ONE;
            iter_start_q <= 1'b1;
            seen_q       <= 1'b0;
            settle_q     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_scheduler.sv
// Bench for iteration_scheduler: two instances (16-bit and 2-bit iteration
// counters) share one stimulus stream and are compared every cycle against a
// behavioural run/flush/finish model, plus directed spot checks.
module tb_iteration_scheduler;
  localparam int CN  = 4;
  localparam int SET = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iteration_scheduler_if #(.CORE_NUM(CN), .ITER_WIDTH(16)) bus_a ();
  iteration_scheduler_if #(.CORE_NUM(CN), .ITER_WIDTH(2))  bus_b ();

  logic          start_v  = 1'b0;
  logic [15:0]   max_v    = '0;
  logic [CN-1:0] end_v    = '0;
  logic [CN-1:0] endval_v = '0;
  logic [CN-1:0] upd_v    = '0;
  logic [CN-1:0] updval_v = '0;

  assign bus_a.start                     = start_v;
  assign bus_a.max_iteration             = max_v;
  assign bus_a.front_iteration_end       = end_v;
  assign bus_a.front_iteration_end_valid = endval_v;
  assign bus_a.front_active_v_updated    = upd_v;
  assign bus_a.front_active_v_valid      = updval_v;
  assign bus_b.start                     = start_v;
  assign bus_b.max_iteration             = max_v[1:0];
  assign bus_b.front_iteration_end       = end_v;
  assign bus_b.front_iteration_end_valid = endval_v;
  assign bus_b.front_active_v_updated    = upd_v;
  assign bus_b.front_active_v_valid      = updval_v;

  iteration_scheduler #(.CORE_NUM(CN), .ITER_WIDTH(16), .SETTLE_CYCLES(SET)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  iteration_scheduler #(.CORE_NUM(CN), .ITER_WIDTH(2), .SETTLE_CYCLES(SET)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  // Behavioural view of one scheduler: is a run in progress, is the flush
  // cycle next, how long the all-ended streak is, and how the run finished.
  typedef struct {
    bit          running;
    bit          flushing;
    bit          first_cycle;
    bit          finished;
    bit          converged;
    bit          any_update;
    int unsigned iter;
    int unsigned limit;
    int unsigned streak;
    int unsigned last_id;
  } model_t;

  model_t ma, mb;
  int total = 0;
  int bad   = 0;

  function automatic model_t model_reset(int unsigned last_id);
    model_t m;
    m.running = 0; m.flushing = 0; m.first_cycle = 0; m.finished = 0;
    m.converged = 0; m.any_update = 0; m.iter = 0; m.limit = 0; m.streak = 0;
    m.last_id = last_id;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, bit st, int unsigned mx, bit ended, bit upd);
    model_t n = m;
    n.first_cycle = 0;
    if (m.flushing) begin
      n.flushing = 0;
      if (!m.any_update) begin
        n.running = 0; n.finished = 1; n.converged = 1;
      end else if (m.limit != 0 && m.iter + 1 == m.limit) begin
        n.running = 0; n.finished = 1; n.converged = 0;
      end else if (m.iter == m.last_id) begin
        n.running = 0; n.finished = 1; n.converged = 0;
      end else begin
        n.iter = m.iter + 1; n.first_cycle = 1; n.any_update = 0; n.streak = 0;
      end
    end else if (m.running) begin
      if (upd) n.any_update = 1;
      if (!m.first_cycle) begin
        n.streak = ended ? m.streak + 1 : 0;
        if (n.streak == SET) begin
          n.flushing = 1; n.streak = 0;
        end
      end
    end else if (st) begin
      n.running = 1; n.finished = 0; n.converged = 0; n.iter = 0;
      n.first_cycle = 1; n.limit = mx & m.last_id; n.any_update = 0; n.streak = 0;
    end
    return n;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("a.iteration_start", 32'(bus_a.iteration_start), 32'(ma.first_cycle));
    check_val("a.iteration_id",    32'(bus_a.iteration_id),    ma.iter);
    check_val("a.core_rst",        32'(bus_a.core_rst),        ma.flushing ? 32'hF : 32'h0);
    check_val("a.busy",            32'(bus_a.busy),            32'(ma.running));
    check_val("a.done",            32'(bus_a.done),            32'(ma.finished));
    check_val("a.done_converged",  32'(bus_a.done_converged),  32'(ma.converged));
    check_val("b.iteration_start", 32'(bus_b.iteration_start), 32'(mb.first_cycle));
    check_val("b.iteration_id",    32'(bus_b.iteration_id),    mb.iter);
    check_val("b.core_rst",        32'(bus_b.core_rst),        mb.flushing ? 32'hF : 32'h0);
    check_val("b.busy",            32'(bus_b.busy),            32'(mb.running));
    check_val("b.done",            32'(bus_b.done),            32'(mb.finished));
    check_val("b.done_converged",  32'(bus_b.done_converged),  32'(mb.converged));
  endtask

  // One clock: check outputs mid-cycle, apply inputs, then advance the model.
  task automatic cycle(bit st, int unsigned mx, logic [CN-1:0] e, logic [CN-1:0] ev,
                       logic [CN-1:0] u, logic [CN-1:0] uv);
    bit ended, upd;
    @(negedge clk);
    check_outputs();
    start_v = st; max_v = 16'(mx); end_v = e; endval_v = ev; upd_v = u; updval_v = uv;
    @(posedge clk);
    ended = &(e & ev);
    upd   = |(u & uv);
    if (!rst) begin
      ma = model_reset(ma.last_id);
      mb = model_reset(mb.last_id);
    end else begin
      ma = model_step(ma, st, mx, ended, upd);
      mb = model_step(mb, st, mx, ended, upd);
    end
  endtask

  // One iteration starting at its iteration_start cycle: late and partial
  // end flags, a stable all-ended run, then the flush cycle with updates
  // that must not count.
  task automatic iter_pattern(bit with_upd, bit start_in_run);
    cycle(0, 0, 4'b0000, 4'b1111, 4'b0010, with_upd ? 4'b0010 : 4'b0000);
    cycle(start_in_run, 1, 4'b1011, 4'b1111, 4'b0000, 4'b0000);
    cycle(start_in_run, 1, 4'b1111, 4'b0111, 4'b0000, 4'b0000);
    repeat (SET) cycle(0, 0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    cycle(0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
  endtask

  initial begin
    logic [CN-1:0] e, ev, u, uv;
    int unsigned rate;
    ma = model_reset(32'hFFFF);
    mb = model_reset(32'h3);
    rate = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Limit of 3 with an update every iteration
    cycle(1, 3, '0, '0, '0, '0);
    repeat (3) iter_pattern(1, 0);
    #1;
    check_val("lim.done", 32'(bus_a.done), 32'd1);
    check_val("lim.conv", 32'(bus_a.done_converged), 32'd0);
    check_val("lim.id",   32'(bus_a.iteration_id), 32'd2);

    // Convergence with no limit
    cycle(1, 0, '0, '0, '0, '0);
    iter_pattern(1, 1);
    iter_pattern(0, 0);
    #1;
    check_val("conv.done", 32'(bus_a.done), 32'd1);
    check_val("conv.conv", 32'(bus_a.done_converged), 32'd1);
    check_val("conv.id",   32'(bus_a.iteration_id), 32'd1);

    // Settle glitch, latency and ignored start while running
    cycle(1, 0, '0, '0, '0, '0);
    cycle(0, 0, 4'b0000, 4'b1111, 4'b0100, 4'b0100);
    cycle(1, 2, 4'b1111, 4'b1111, '0, '0);
    cycle(1, 2, 4'b1111, 4'b1011, '0, '0);
    cycle(0, 0, 4'b1111, 4'b1111, '0, '0);
    #1;
    check_val("glitch.no_switch", 32'(bus_a.core_rst), 32'h0);
    cycle(0, 0, 4'b1111, 4'b1111, '0, '0);
    #1;
    check_val("lat.core_rst_k1", 32'(bus_a.core_rst), 32'hF);
    cycle(0, 0, '0, '0, '0, '0);
    #1;
    check_val("lat.core_rst_k2",   32'(bus_a.core_rst), 32'h0);
    check_val("lat.iter_start_k2", 32'(bus_a.iteration_start), 32'd1);
    check_val("lat.id_k2",         32'(bus_a.iteration_id), 32'd1);
    iter_pattern(0, 0);

    // Asynchronous reset while in the flush cycle
    cycle(1, 0, '0, '0, '0, '0);
    cycle(0, 0, 4'b0000, 4'b1111, 4'b0001, 4'b0001);
    repeat (SET) cycle(0, 0, 4'b1111, 4'b1111, '0, '0);
    #1;
    check_val("rst.in_switch", 32'(bus_a.core_rst), 32'hF);
    #2 rst = 1'b0;
    #1;
    ma = model_reset(ma.last_id);
    mb = model_reset(mb.last_id);
    check_val("rst.core_rst", 32'(bus_a.core_rst), 32'h0);
    check_val("rst.busy",     32'(bus_a.busy), 32'd0);
    check_val("rst.id",       32'(bus_a.iteration_id), 32'd0);
    repeat (2) cycle(1, 0, '0, '0, '0, '0);
    #1 rst = 1'b1;
    repeat (3) cycle(0, 0, 4'b1111, 4'b1111, 4'b1111, 4'b1111);

    // Counter exhaustion on the 2-bit instance
    cycle(1, 0, '0, '0, '0, '0);
    repeat (4) iter_pattern(1, 0);
    #1;
    check_val("exh.done", 32'(bus_b.done), 32'd1);
    check_val("exh.conv", 32'(bus_b.done_converged), 32'd0);
    check_val("exh.id",   32'(bus_b.iteration_id), 32'd3);
    check_val("exh.a_id", 32'(bus_a.iteration_id), 32'd4);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (c % 25 == 0) rate = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      for (int k = 0; k < CN; k++) begin
        e[k]  = ($urandom_range(0, 11) != 0);
        ev[k] = ($urandom_range(0, 11) != 0);
        u[k]  = ($urandom_range(0, 31) < rate);
        uv[k] = ($urandom_range(0, 3) != 0);
      end
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5), e, ev, u, uv);
    end
    @(negedge clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
